// File: rtl/ifft8_pkg.sv
// Shared constants, FSM state type and number-format helpers for the
// sequential 8-point inverse FFT.
`timescale 1ns/1ps
package ifft8_pkg;

    localparam int DATA_W = 32;     // external sign-magnitude width
    localparam int ACC_W  = 36;     // internal two's-complement width
    localparam int TW_C   = 23170;  // cos(pi/4) in Q15
    localparam int TW_Q   = 15;     // twiddle fraction bits

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        COMP  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Bin k lands at bit-reversed address so the in-place DIT stages
    // produce natural-order time samples.
    function automatic logic [2:0] bitrev3(input logic [2:0] k);
        return {k[0], k[1], k[2]};
    endfunction

    // Sign-magnitude to two's complement; -0 folds to 0 naturally.
    function automatic logic signed [ACC_W-1:0] sm_to_tc(input logic [DATA_W-1:0] sm);
        logic signed [ACC_W-1:0] mag;
        mag = {{(ACC_W-DATA_W+1){1'b0}}, sm[DATA_W-2:0]};
        return sm[DATA_W-1] ? -mag : mag;
    endfunction

    // Two's complement to sign-magnitude with the 1/8 inverse scaling:
    // magnitude truncated toward zero, saturated, and never a negative zero.
    function automatic logic [DATA_W-1:0] tc_to_sm(input logic signed [ACC_W-1:0] v);
        logic              neg;
        logic [ACC_W:0]    ext_v;
        logic [ACC_W:0]    abs_v;
        logic [ACC_W:0]    mag;
        logic [DATA_W-2:0] mag_sat;
        neg   = v[ACC_W-1];
        ext_v = {v[ACC_W-1], v};
        abs_v = neg ? -ext_v : ext_v;
        mag   = abs_v >> 3;
        if (|mag[ACC_W:DATA_W-1]) begin
            mag_sat = '1;
        end else begin
            mag_sat = mag[DATA_W-2:0];
        end
        return {neg && (mag_sat != '0), mag_sat};
    endfunction

endpackage

// File: rtl/ifft8_bfly.sv
// Combinational radix-2 DIT butterfly with inverse twiddles W^-k, k = 0..3.
// t = W^-k * x[q];  y[p] = x[p] + t;  y[q] = x[p] - t.
`timescale 1ns/1ps
module ifft8_bfly
    import ifft8_pkg::*;
(
    input  logic signed [ACC_W-1:0] xp_re_i,
    input  logic signed [ACC_W-1:0] xp_im_i,
    input  logic signed [ACC_W-1:0] xq_re_i,
    input  logic signed [ACC_W-1:0] xq_im_i,
    input  logic        [1:0]       k_i,
    output logic signed [ACC_W-1:0] yp_re_o,
    output logic signed [ACC_W-1:0] yp_im_o,
    output logic signed [ACC_W-1:0] yq_re_o,
    output logic signed [ACC_W-1:0] yq_im_o
);

    localparam int SUM_W  = ACC_W + 1;
    localparam int PROD_W = SUM_W + 16;
    localparam logic signed [15:0]       TW_C16 = 16'(TW_C);
    localparam logic signed [PROD_W-1:0] HALF   = PROD_W'(1) <<< (TW_Q - 1);

    logic signed [SUM_W-1:0]  a_w, b_w, apb, amb;
    logic signed [PROD_W-1:0] p_amb, p_apb, p_napb;
    logic signed [ACC_W-1:0]  t_re, t_im;

    // Round half up, then drop the Q15 fraction.
    function automatic logic signed [ACC_W-1:0] rnd(input logic signed [PROD_W-1:0] v);
        logic signed [PROD_W-1:0] s;
        s = v + HALF;
        s = s >>> TW_Q;
        return ACC_W'(s);
    endfunction

    // The a+-b sums get one extra bit so they cannot wrap before the multiply.
    assign a_w    = SUM_W'(xq_re_i);
    assign b_w    = SUM_W'(xq_im_i);
    assign apb    = a_w + b_w;
    assign amb    = a_w - b_w;
    assign p_amb  = PROD_W'(amb) * PROD_W'(TW_C16);
    assign p_apb  = PROD_W'(apb) * PROD_W'(TW_C16);
    assign p_napb = -p_apb;

    // Twiddle multiply: trivial for k = 0 and 2, Q15 products for k = 1 and 3.
    always_comb begin
        t_re = xq_re_i;
        t_im = xq_im_i;
        case (k_i)
            2'd1: begin
                t_re = rnd(p_amb);
                t_im = rnd(p_apb);
            end
            2'd2: begin
                t_re = -xq_im_i;
                t_im = xq_re_i;
            end
            2'd3: begin
                t_re = rnd(p_napb);
                t_im = rnd(p_amb);
            end
            default: begin
                t_re = xq_re_i;
                t_im = xq_im_i;
            end
        endcase
    end

    assign yp_re_o = xp_re_i + t_re;
    assign yp_im_o = xp_im_i + t_im;
    assign yq_re_o = xp_re_i - t_re;
    assign yq_im_o = xp_im_i - t_im;

endmodule

// File: rtl/ifft8_seq.sv
// Sequential 8-point inverse FFT: load 8 bins, run 12 in-place butterflies
// through one shared butterfly, then stream 8 time samples scaled by 1/8.
`timescale 1ns/1ps
module ifft8_seq
    import ifft8_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_re,
    input  logic [DATA_W-1:0] in_im,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_re,
    output logic [DATA_W-1:0] out_im,
    output logic [2:0]        out_idx,
    output logic              out_last,
    output logic              busy
);

    state_t            state_q, state_d;
    logic [2:0]        in_cnt_q, in_cnt_d;
    logic [3:0]        step_q, step_d;
    logic [2:0]        out_idx_q, out_idx_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] out_re_q, out_re_d;
    logic [DATA_W-1:0] out_im_q, out_im_d;

    logic signed [ACC_W-1:0] buf_re_q [8];
    logic signed [ACC_W-1:0] buf_im_q [8];

    logic [1:0] stage;
    logic [1:0] bidx;
    logic [2:0] p_addr, q_addr;
    logic [1:0] tw_k;
    logic [2:0] load_addr;
    logic [2:0] nxt_idx;
    logic       accept, xfer;
    logic       load_we, comp_we;
    logic [7:0] we_load, we_p, we_q;
    logic signed [ACC_W-1:0] load_re, load_im;
    logic signed [ACC_W-1:0] yp_re, yp_im, yq_re, yq_im;

    assign accept    = (state_q == LOAD) && in_valid && in_ready_q;
    assign xfer      = (state_q == DRAIN) && out_valid_q && out_ready;
    assign load_addr = bitrev3(in_cnt_q);
    assign load_re   = sm_to_tc(in_re);
    assign load_im   = sm_to_tc(in_im);
    assign nxt_idx   = out_idx_q + 3'd1;
    assign stage     = step_q[3:2];
    assign bidx      = step_q[1:0];
    assign load_we   = accept;
    assign comp_we   = (state_q == COMP);

    // Butterfly addressing: span h = 1,2,4 per stage, p = g*2h + j, q = p + h, k = j*(4/h).
    always_comb begin
        p_addr = 3'd0;
        q_addr = 3'd0;
        tw_k   = 2'd0;
        case (stage)
            2'd0: begin
                p_addr = {bidx, 1'b0};
                q_addr = {bidx, 1'b1};
                tw_k   = 2'd0;
            end
            2'd1: begin
                p_addr = {bidx[1], 1'b0, bidx[0]};
                q_addr = {bidx[1], 1'b1, bidx[0]};
                tw_k   = {bidx[0], 1'b0};
            end
            default: begin
                p_addr = {1'b0, bidx};
                q_addr = {1'b1, bidx};
                tw_k   = bidx;
            end
        endcase
    end

    ifft8_bfly u_bfly (
        .xp_re_i (buf_re_q[p_addr]),
        .xp_im_i (buf_im_q[p_addr]),
        .xq_re_i (buf_re_q[q_addr]),
        .xq_im_i (buf_im_q[q_addr]),
        .k_i     (tw_k),
        .yp_re_o (yp_re),
        .yp_im_o (yp_im),
        .yq_re_o (yq_re),
        .yq_im_o (yq_im)
    );

    // Per-entry write enables for the two write ports.
    for (genvar gi = 0; gi < 8; gi++) begin : g_we
        assign we_load[gi] = load_we && (load_addr == 3'(gi));
        assign we_p[gi]    = comp_we && (p_addr == 3'(gi));
        assign we_q[gi]    = comp_we && (q_addr == 3'(gi));
    end

    // Working buffer: loaded in bit-reversed order, updated in place by each butterfly.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (we_load[i]) begin
                buf_re_q[i] <= load_re;
                buf_im_q[i] <= load_im;
            end else if (we_p[i]) begin
                buf_re_q[i] <= yp_re;
                buf_im_q[i] <= yp_im;
            end else if (we_q[i]) begin
                buf_re_q[i] <= yq_re;
                buf_im_q[i] <= yq_im;
            end
        end
    end

    // Next-state, counters and registered outputs; every output is a register.
    always_comb begin
        state_d     = state_q;
        in_cnt_d    = in_cnt_q;
        step_d      = step_q;
        out_idx_d   = out_idx_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;
        out_re_d    = out_re_q;
        out_im_d    = out_im_q;
        case (state_q)
            LOAD: begin
                if (accept) begin
                    in_cnt_d = in_cnt_q + 3'd1;
                    if (in_cnt_q == 3'd7) begin
                        state_d    = COMP;
                        step_d     = 4'd0;
                        in_ready_d = 1'b0;
                        busy_d     = 1'b1;
                    end
                end
            end
            COMP: begin
                step_d = step_q + 4'd1;
                // Entry 0 is final after the first stage-2 butterfly, so the
                // first sample can be registered on the last compute cycle.
                if (step_q == 4'd11) begin
                    state_d     = DRAIN;
                    out_valid_d = 1'b1;
                    out_idx_d   = 3'd0;
                    out_last_d  = 1'b0;
                    out_re_d    = tc_to_sm(buf_re_q[0]);
                    out_im_d    = tc_to_sm(buf_im_q[0]);
                end
            end
            DRAIN: begin
                if (xfer) begin
                    if (out_idx_q == 3'd7) begin
                        state_d     = LOAD;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        out_idx_d   = 3'd0;
                        in_cnt_d    = 3'd0;
                        in_ready_d  = 1'b1;
                        busy_d      = 1'b0;
                    end else begin
                        out_idx_d  = nxt_idx;
                        out_last_d = (nxt_idx == 3'd7);
                        out_re_d   = tc_to_sm(buf_re_q[nxt_idx]);
                        out_im_d   = tc_to_sm(buf_im_q[nxt_idx]);
                    end
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    // State and output registers; reset drops any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= LOAD;
            in_cnt_q    <= 3'd0;
            step_q      <= 4'd0;
            out_idx_q   <= 3'd0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
        end else begin
            state_q     <= state_d;
            in_cnt_q    <= in_cnt_d;
            step_q      <= step_d;
            out_idx_q   <= out_idx_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_ifft8_seq.sv
// Directed bench for ifft8_seq: impulses, round trip, backpressure, resets, saturation.
`timescale 1ns/1ps
module tb_ifft8_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_re;
    logic [31:0] in_im;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_re;
    logic [31:0] out_im;
    logic [2:0]  out_idx;
    logic        out_last;
    logic        busy;

    int n_checks;
    int n_errors;
    int cyc;
    int accept_cyc;

    logic [31:0] bin_re [8];
    logic [31:0] bin_im [8];
    int          exp_re [8];
    int          exp_im [8];

    ifft8_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic logic [31:0] int2sm(input int v);
        if (v < 0) return {1'b1, 31'(-v)};
        return {1'b0, 31'(v)};
    endfunction

    function automatic longint sm2int(input logic [31:0] x);
        if (x[31]) return -longint'(x[30:0]);
        return longint'(x[30:0]);
    endfunction

    // Within tolerance -> report the expected encoding, otherwise the raw value.
    function automatic logic [31:0] near(input logic [31:0] act, input int exp, input int tol);
        longint a;
        if (tol == 0) return act;
        a = sm2int(act);
        if ((a - exp <= tol) && (exp - a <= tol)) return int2sm(exp);
        return act;
    endfunction

    task automatic clear_frame();
        for (int i = 0; i < 8; i++) begin
            bin_re[i] = 32'd0;
            bin_im[i] = 32'd0;
            exp_re[i] = 0;
            exp_im[i] = 0;
        end
    endtask

    task automatic send_frame(input int gap_pct);
        int  k;
        int  guard;
        logic vld;
        logic rdy;
        k = 0;
        guard = 0;
        while (k < 8 && guard < 500) begin
            vld = !(gap_pct > 0 && $urandom_range(0, 99) < gap_pct);
            in_valid = vld;
            in_re = bin_re[k];
            in_im = bin_im[k];
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (vld && rdy) begin
                k++;
                accept_cyc = cyc;
            end
            guard++;
        end
        in_valid = 1'b0;
        in_re = 32'd0;
        in_im = 32'd0;
        if (k < 8) check("send_timeout", 64'(k), 64'd8);
    endtask

    task automatic recv_frame(input string name, input int stall_pct, input int tol, input bit chk_lat);
        int          n;
        int          guard;
        bit          first;
        logic        v;
        logic        r;
        logic [31:0] s_re;
        logic [31:0] s_im;
        logic [2:0]  s_idx;
        logic        s_last;
        n = 0;
        guard = 0;
        first = 1'b1;
        while (n < 8 && guard < 2000) begin
            r = !(stall_pct > 0 && $urandom_range(0, 99) < stall_pct);
            out_ready = r;
            v = out_valid;
            s_re = out_re;
            s_im = out_im;
            s_idx = out_idx;
            s_last = out_last;
            if (v && first) begin
                first = 1'b0;
                if (chk_lat) check($sformatf("%s_latency", name), 64'(cyc - accept_cyc), 64'd12);
            end
            @(posedge clk);
            #1;
            if (v && r) begin
                $display("%s n=%0d idx=%0d re=%0d im=%0d last=%0b", name, n, s_idx,
                         sm2int(s_re), sm2int(s_im), s_last);
                check($sformatf("%s_re[%0d]", name, n), 64'(near(s_re, exp_re[n], tol)), 64'(int2sm(exp_re[n])));
                check($sformatf("%s_im[%0d]", name, n), 64'(near(s_im, exp_im[n], tol)), 64'(int2sm(exp_im[n])));
                check($sformatf("%s_idx[%0d]", name, n), 64'(s_idx), 64'(n));
                check($sformatf("%s_last[%0d]", name, n), 64'(s_last), 64'(n == 7));
                n++;
            end else if (v) begin
                check($sformatf("%s_hold_re", name), 64'(out_re), 64'(s_re));
                check($sformatf("%s_hold_im", name), 64'(out_im), 64'(s_im));
                check($sformatf("%s_hold_ctl", name), 64'({out_valid, out_idx, out_last}), 64'({1'b1, s_idx, s_last}));
            end
            guard++;
        end
        out_ready = 1'b0;
        if (n < 8) check($sformatf("%s_timeout", name), 64'(n), 64'd8);
    endtask

    task automatic impulse_frame();
        clear_frame();
        bin_re[0] = 32'd800;
        for (int i = 0; i < 8; i++) exp_re[i] = 100;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc = 0;
        accept_cyc = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_re = 32'd0;
        in_im = 32'd0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_re", 64'(out_re), 64'd0);
        check("rst_out_im", 64'(out_im), 64'd0);
        check("rst_out_idx", 64'(out_idx), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);

        // Impulse at bin 0
        impulse_frame();
        send_frame(0);
        check("imp_busy", 64'(busy), 64'd1);
        check("imp_in_ready", 64'(in_ready), 64'd0);
        recv_frame("imp", 0, 0, 1'b1);

        // Bin 4: alternating sign
        clear_frame();
        bin_re[4] = 32'd800;
        for (int i = 0; i < 8; i++) exp_re[i] = (i % 2 == 0) ? 100 : -100;
        send_frame(0);
        recv_frame("bin4", 0, 0, 1'b1);

        // Bin 2: quarter-rate rotation
        clear_frame();
        bin_re[2] = 32'd800;
        exp_re = '{100, 0, -100, 0, 100, 0, -100, 0};
        exp_im = '{0, 100, 0, -100, 0, 100, 0, -100};
        send_frame(0);
        recv_frame("bin2", 0, 0, 1'b1);

        // Round trip of forward-transformed A = 120,130,0,110,0,150,200,0
        clear_frame();
        bin_re[0] = int2sm(710);  bin_im[0] = int2sm(0);
        bin_re[1] = int2sm(28);   bin_im[1] = int2sm(136);
        bin_re[2] = int2sm(-80);  bin_im[2] = int2sm(-170);
        bin_re[3] = int2sm(212);  bin_im[3] = int2sm(-264);
        bin_re[4] = int2sm(-70);  bin_im[4] = int2sm(0);
        bin_re[5] = int2sm(212);  bin_im[5] = int2sm(264);
        bin_re[6] = int2sm(-80);  bin_im[6] = int2sm(170);
        bin_re[7] = int2sm(28);   bin_im[7] = int2sm(-136);
        exp_re = '{120, 130, 0, 110, 0, 150, 200, 0};
        send_frame(0);
        recv_frame("rt", 0, 2, 1'b1);

        // Backpressure and input gaps on the bin-2 frame
        clear_frame();
        bin_re[2] = 32'd800;
        exp_re = '{100, 0, -100, 0, 100, 0, -100, 0};
        exp_im = '{0, 100, 0, -100, 0, 100, 0, -100};
        send_frame(30);
        recv_frame("bp", 40, 0, 1'b0);

        // Reset mid-LOAD: three stray bins then reset
        in_valid = 1'b1;
        in_re = 32'd400;
        in_im = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rstload_in_ready", 64'(in_ready), 64'd1);
        impulse_frame();
        send_frame(0);
        recv_frame("rstload", 0, 0, 1'b1);

        // Reset mid-COMP
        clear_frame();
        bin_re[3] = 32'd640;
        send_frame(0);
        repeat (5) @(posedge clk);
        #1;
        check("rstcomp_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rstcomp_out_valid", 64'(out_valid), 64'd0);
        check("rstcomp_in_ready", 64'(in_ready), 64'd1);
        check("rstcomp_busy", 64'(busy), 64'd0);
        impulse_frame();
        send_frame(0);
        recv_frame("rstcomp", 0, 0, 1'b1);

        // Full-scale DC: n = 0 reaches the largest magnitude
        clear_frame();
        for (int i = 0; i < 8; i++) bin_re[i] = 32'h7FFF_FFFF;
        exp_re[0] = 2147483647;
        send_frame(0);
        recv_frame("sat", 0, 0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
